// File: rtl/csa_accumulator_pkg.sv
// Shared types and constant helpers for the carry-save accumulator:
// FSM state encoding, compressor-tree sizing and operand extension.
package csa_pkg;

   typedef enum logic [1:0] {
      ACCUM   = 2'd0,
      RESOLVE = 2'd1,
      OUT     = 2'd2
   } state_t;

   // Widest accumulator the extension helper supports.
   localparam int CSA_MAX_W = 64;
   localparam int CSA_IDX_W = $clog2(CSA_MAX_W);

   // Operand count left after one level of 3:2 compression.
   function automatic int csa_step(input int n);
      return 2 * (n / 3) + (n % 3);
   endfunction

   // Operand count present at the input of tree level lvl.
   function automatic int csa_count(input int n, input int lvl);
      int c;
      c = n;
      for (int i = 0; i < lvl; i++) c = csa_step(c);
      return c;
   endfunction

   // Number of 3:2 levels needed to reduce n operands to two.
   function automatic int csa_levels(input int n);
      int c;
      int l;
      c = n;
      l = 0;
      while (c > 2) begin
         c = csa_step(c);
         l++;
      end
      return l;
   endfunction

   // Extends the low w bits of v: sign-extends when sgn=1, else zero-extends.
   function automatic logic [CSA_MAX_W-1:0] csa_ext(input logic [CSA_MAX_W-1:0] v,
                                                    input int w, input bit sgn);
      logic [CSA_MAX_W-1:0] r;
      logic                 msb;
      msb = sgn & v[CSA_IDX_W'(w - 1)];
      for (int i = 0; i < CSA_MAX_W; i++) r[i] = (i < w) ? v[i] : msb;
      return r;
   endfunction

endpackage

// File: rtl/csa_accumulator_if.sv
// Bus bundle for the accumulator: input beat channel and result channel.
// Both channels use valid/ready: a transfer happens on a rising clk edge where
// valid and ready are both 1; a source holding valid keeps its payload stable
// until that edge, and valid never depends combinationally on ready.
interface csa_accumulator_if #(
   parameter int IN_WIDTH  = 12,
   parameter int NUM_IN    = 3,
   parameter int ACC_WIDTH = 32,
   parameter int CNT_WIDTH = 16
) ();

   logic                        in_valid;
   logic                        in_ready;
   logic [NUM_IN*IN_WIDTH-1:0]  in_data;
   logic                        in_last;
   logic                        out_valid;
   logic                        out_ready;
   logic [ACC_WIDTH-1:0]        out_data;
   logic [CNT_WIDTH-1:0]        out_beats;

   modport master (
      output in_valid, in_data, in_last, out_ready,
      input  in_ready, out_valid, out_data, out_beats
   );

   modport slave (
      input  in_valid, in_data, in_last, out_ready,
      output in_ready, out_valid, out_data, out_beats
   );

endinterface

// File: rtl/csa_accumulator_3to2.sv
// W-bit 3:2 compressor: three vectors in, sum and left-shifted carry out.
// The carry out of the MSB is dropped so everything wraps modulo 2^W.
module csa_3to2_n #(
   parameter int W = 32
) (
   input  logic [W-1:0] i_a,
   input  logic [W-1:0] i_b,
   input  logic [W-1:0] i_c,
   output logic [W-1:0] o_s,
   output logic [W-1:0] o_cout
);

   assign o_s    = i_a ^ i_b ^ i_c;
   assign o_cout = {(i_a[W-2:0] & i_b[W-2:0]) |
                    (i_a[W-2:0] & i_c[W-2:0]) |
                    (i_b[W-2:0] & i_c[W-2:0]), 1'b0};

endmodule

// File: rtl/csa_accumulator.sv
// Multi-operand carry-save accumulator. Each beat's operands are folded with
// the redundant (sum, carry) pair through a 3:2 tree; the last beat of a group
// triggers a single carry-propagate add whose result goes out via valid/ready.
module csa_accumulator
   import csa_pkg::*;
#(
   parameter int IN_WIDTH  = 12,
   parameter int NUM_IN    = 3,
   parameter int ACC_WIDTH = 32,
   parameter int SIGNED    = 0,
   parameter int CNT_WIDTH = 16
) (
   input  logic                clk,
   input  logic                rst,
   csa_accumulator_if.slave    s_bus,
   output state_t              o_state
);

   localparam int N_OPS = NUM_IN + 2;
   localparam int N_LVL = csa_levels(N_OPS);

   state_t                 r_state;
   state_t                 w_state_nxt;
   logic                   w_in_ready;
   logic                   w_accept;

   logic [ACC_WIDTH-1:0]   r_sum;
   logic [ACC_WIDTH-1:0]   r_carry;
   logic [CNT_WIDTH-1:0]   r_cnt;
   logic [ACC_WIDTH-1:0]   r_out_data;
   logic [CNT_WIDTH-1:0]   r_out_beats;
   logic                   r_out_valid;

   // Operand vectors at every tree level; level 0 holds the pair plus the beat.
   logic [ACC_WIDTH-1:0]   w_ops [N_LVL+1][N_OPS];
   logic [ACC_WIDTH-1:0]   w_sum_nxt;
   logic [ACC_WIDTH-1:0]   w_carry_nxt;

   assign w_ops[0][0] = r_sum;
   assign w_ops[0][1] = r_carry;

   for (genvar i = 0; i < NUM_IN; i++) begin : g_ext
      assign w_ops[0][i+2] = ACC_WIDTH'(csa_ext(
         CSA_MAX_W'(s_bus.in_data[i*IN_WIDTH +: IN_WIDTH]), IN_WIDTH, SIGNED != 0));
   end

   // Each level compresses full groups of three and passes the remainder on;
   // slots beyond the live operand count are tied to zero.
   for (genvar l = 0; l < N_LVL; l++) begin : g_lvl
      localparam int N_CUR = csa_count(N_OPS, l);
      localparam int N_GRP = N_CUR / 3;
      localparam int N_REM = N_CUR % 3;

      for (genvar g = 0; g < N_GRP; g++) begin : g_csa
         csa_3to2_n #(.W(ACC_WIDTH)) u_csa (
            .i_a    (w_ops[l][3*g]),
            .i_b    (w_ops[l][3*g+1]),
            .i_c    (w_ops[l][3*g+2]),
            .o_s    (w_ops[l+1][2*g]),
            .o_cout (w_ops[l+1][2*g+1])
         );
      end

      for (genvar k = 0; k < N_REM; k++) begin : g_pass
         assign w_ops[l+1][2*N_GRP+k] = w_ops[l][3*N_GRP+k];
      end

      for (genvar z = 2*N_GRP + N_REM; z < N_OPS; z++) begin : g_tie
         assign w_ops[l+1][z] = '0;
      end
   end

   assign w_sum_nxt   = w_ops[N_LVL][0];
   assign w_carry_nxt = w_ops[N_LVL][1];

   assign w_accept = s_bus.in_valid & w_in_ready;

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= ACCUM;
      else     r_state <= w_state_nxt;
   end

   // Next-state and input-ready decode.
   always_comb begin
      w_state_nxt = r_state;
      w_in_ready  = 1'b0;
      case (r_state)
         ACCUM: begin
            w_in_ready = 1'b1;
            if (s_bus.in_valid && s_bus.in_last) w_state_nxt = RESOLVE;
         end
         RESOLVE: w_state_nxt = OUT;
         OUT: begin
            if (s_bus.out_ready) w_state_nxt = ACCUM;
         end
         default: w_state_nxt = ACCUM;
      endcase
   end

   // Accumulate on accepted beats, resolve once per group, clear after output.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sum       <= '0;
         r_carry     <= '0;
         r_cnt       <= '0;
         r_out_data  <= '0;
         r_out_beats <= '0;
         r_out_valid <= 1'b0;
      end else begin
         case (r_state)
            ACCUM: begin
               if (w_accept) begin
                  r_sum   <= w_sum_nxt;
                  r_carry <= w_carry_nxt;
                  if (r_cnt != {CNT_WIDTH{1'b1}}) r_cnt <= r_cnt + 1'b1;
               end
            end
            RESOLVE: begin
               r_out_data  <= r_sum + r_carry;
               r_out_beats <= r_cnt;
               r_out_valid <= 1'b1;
            end
            OUT: begin
               if (s_bus.out_ready) begin
                  r_out_valid <= 1'b0;
                  r_sum       <= '0;
                  r_carry     <= '0;
                  r_cnt       <= '0;
               end
            end
            default: ;
         endcase
      end
   end

   assign s_bus.in_ready  = w_in_ready;
   assign s_bus.out_valid = r_out_valid;
   assign s_bus.out_data  = r_out_data;
   assign s_bus.out_beats = r_out_beats;
   assign o_state         = r_state;

endmodule

// File: tb/tb_csa_accumulator.sv
// Bench for csa_accumulator: three instances (unsigned default, signed,
// 14-bit accumulator with a 2-bit beat counter) driven by directed beats.
// Expected results are queued when a group is issued; per-instance monitors
// pop and compare whenever a result is handed over.
module tb_csa_accumulator;
   import csa_pkg::*;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   logic [2:0]  t_vld;
   logic [2:0]  t_last;
   logic [2:0]  t_ordy;
   logic [35:0] t_data [3];

   state_t st_a, st_b, st_c;
   logic [47:0] obs_a, obs_b, obs_c;

   logic [47:0] exp_q_a[$];
   logic [47:0] exp_q_b[$];
   logic [47:0] exp_q_c[$];

   csa_accumulator_if #(.IN_WIDTH(12), .NUM_IN(3), .ACC_WIDTH(32), .CNT_WIDTH(16)) if_a ();
   csa_accumulator_if #(.IN_WIDTH(12), .NUM_IN(3), .ACC_WIDTH(32), .CNT_WIDTH(16)) if_b ();
   csa_accumulator_if #(.IN_WIDTH(12), .NUM_IN(3), .ACC_WIDTH(14), .CNT_WIDTH(2))  if_c ();

   assign if_a.in_valid  = t_vld[0];
   assign if_a.in_last   = t_last[0];
   assign if_a.in_data   = t_data[0];
   assign if_a.out_ready = t_ordy[0];
   assign if_b.in_valid  = t_vld[1];
   assign if_b.in_last   = t_last[1];
   assign if_b.in_data   = t_data[1];
   assign if_b.out_ready = t_ordy[1];
   assign if_c.in_valid  = t_vld[2];
   assign if_c.in_last   = t_last[2];
   assign if_c.in_data   = t_data[2];
   assign if_c.out_ready = t_ordy[2];

   // Observed results packed as {beats[15:0], data[31:0]}.
   assign obs_a = {if_a.out_beats, if_a.out_data};
   assign obs_b = {if_b.out_beats, if_b.out_data};
   assign obs_c = {14'd0, if_c.out_beats, 18'd0, if_c.out_data};

   csa_accumulator #(.IN_WIDTH(12), .NUM_IN(3), .ACC_WIDTH(32), .SIGNED(0), .CNT_WIDTH(16))
      u_dut_a (.clk(clk), .rst(rst), .s_bus(if_a), .o_state(st_a));
   csa_accumulator #(.IN_WIDTH(12), .NUM_IN(3), .ACC_WIDTH(32), .SIGNED(1), .CNT_WIDTH(16))
      u_dut_b (.clk(clk), .rst(rst), .s_bus(if_b), .o_state(st_b));
   csa_accumulator #(.IN_WIDTH(12), .NUM_IN(3), .ACC_WIDTH(14), .SIGNED(0), .CNT_WIDTH(2))
      u_dut_c (.clk(clk), .rst(rst), .s_bus(if_c), .o_state(st_c));

   // ---------------- helpers / driver tasks ----------------
   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic logic rdy(input int s);
      case (s)
         0:       return if_a.in_ready;
         1:       return if_b.in_ready;
         default: return if_c.in_ready;
      endcase
   endfunction

   function automatic logic ov(input int s);
      case (s)
         0:       return if_a.out_valid;
         1:       return if_b.out_valid;
         default: return if_c.out_valid;
      endcase
   endfunction

   task automatic push_exp(input int s, input logic [15:0] beats, input logic [31:0] data);
      case (s)
         0:       exp_q_a.push_back({beats, data});
         1:       exp_q_b.push_back({beats, data});
         default: exp_q_c.push_back({beats, data});
      endcase
   endtask

   // Presents one beat and returns #1 after the edge that accepted it.
   task automatic send_beat(input int s, input logic [35:0] d, input logic lst);
      int n;
      n = 0;
      @(negedge clk);
      t_vld[s]  = 1'b1;
      t_data[s] = d;
      t_last[s] = lst;
      while (!rdy(s) && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) begin
         n_tests++;
         n_fail++;
         $display("FAIL send_timeout: inst %0d in_ready stuck at 0", s);
         t_vld[s]  = 1'b0;
         t_last[s] = 1'b0;
      end else begin
         @(posedge clk);
         #1;
         t_vld[s]  = 1'b0;
         t_last[s] = 1'b0;
      end
   endtask

   // ---------------- scoreboard monitors ----------------
   always @(negedge clk) begin
      if (!rst && if_a.out_valid && t_ordy[0]) begin
         if (exp_q_a.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL mon_a: unexpected result %h", obs_a);
         end else check("mon_a", 64'(obs_a), 64'(exp_q_a.pop_front()));
      end
   end

   always @(negedge clk) begin
      if (!rst && if_b.out_valid && t_ordy[1]) begin
         if (exp_q_b.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL mon_b: unexpected result %h", obs_b);
         end else check("mon_b", 64'(obs_b), 64'(exp_q_b.pop_front()));
      end
   end

   always @(negedge clk) begin
      if (!rst && if_c.out_valid && t_ordy[2]) begin
         if (exp_q_c.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL mon_c: unexpected result %h", obs_c);
         end else check("mon_c", 64'(obs_c), 64'(exp_q_c.pop_front()));
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   // ---------------- stimulus ----------------
   initial begin
      logic r0, r1, r2;
      int   n;
      t_vld  = '0;
      t_last = '0;
      t_ordy = '1;
      for (int i = 0; i < 3; i++) t_data[i] = '0;

      // Reset values while reset is held.
      #1;
      check("rst_out_a", 64'(obs_a), 64'd0);
      check("rst_valid", 64'({ov(0), ov(1), ov(2)}), 64'd0);
      check("rst_state", 64'({st_a, st_b, st_c}), 64'd0);
      #22 rst = 1'b0;
      @(negedge clk);
      check("rdy_after_rst", 64'({rdy(0), rdy(1), rdy(2)}), 64'b111);

      // in_last without in_valid changes nothing.
      t_last[0] = 1'b1;
      @(posedge clk);
      #1;
      check("last_no_valid", 64'({st_a, rdy(0)}), {61'd0, ACCUM, 1'b1});
      t_last[0] = 1'b0;

      // Single-beat group and its latency.
      push_exp(0, 16'd1, 32'h0000_2FFD);
      send_beat(0, {12'hFFF, 12'hFFF, 12'hFFF}, 1'b1);
      check("lat_resolve", 64'({st_a, ov(0), rdy(0)}), {60'd0, RESOLVE, 2'b00});
      @(posedge clk);
      #1;
      check("lat_valid", 64'({ov(0), rdy(0)}), 64'b10);
      @(posedge clk);
      #1;
      check("lat_return", 64'({ov(0), rdy(0)}), 64'b01);

      // Four-beat group; in_ready low for RESOLVE plus one OUT cycle.
      push_exp(0, 16'd4, 32'h0000_0018);
      for (int i = 0; i < 4; i++) send_beat(0, {12'd3, 12'd2, 12'd1}, i == 3);
      r0 = rdy(0);
      @(posedge clk);
      #1;
      r1 = rdy(0);
      @(posedge clk);
      #1;
      r2 = rdy(0);
      check("multi_rdy", 64'({r0, r1, r2}), 64'b001);

      // Signed operands, single and two-beat groups.
      push_exp(1, 16'd1, 32'hFFFF_F800);
      send_beat(1, {12'hFFF, 12'h001, 12'h800}, 1'b1);
      push_exp(1, 16'd2, 32'hFFFF_FFFF);
      send_beat(1, {12'hFFF, 12'hFFF, 12'hFFF}, 1'b0);
      send_beat(1, {12'h000, 12'h000, 12'h002}, 1'b1);

      // 14-bit wrap, then beat counter saturation at 3.
      push_exp(2, 16'd2, 32'h0000_1FFA);
      send_beat(2, {12'hFFF, 12'hFFF, 12'hFFF}, 1'b0);
      send_beat(2, {12'hFFF, 12'hFFF, 12'hFFF}, 1'b1);
      push_exp(2, 16'd3, 32'h0000_0005);
      for (int i = 0; i < 5; i++) send_beat(2, {12'd0, 12'd0, 12'd1}, i == 4);

      // Backpressure: result held, incoming beat ignored.
      t_ordy[0] = 1'b0;
      push_exp(0, 16'd1, 32'h0000_0060);
      send_beat(0, {12'h030, 12'h020, 12'h010}, 1'b1);
      @(posedge clk);
      #1;
      t_vld[0]  = 1'b1;
      t_last[0] = 1'b1;
      t_data[0] = {12'h007, 12'h007, 12'h007};
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("bp_hold", 64'({ov(0), rdy(0), obs_a}), {14'd0, 1'b1, 1'b0, 16'd1, 32'h60});
      end
      @(posedge clk);
      #1;
      t_vld[0]  = 1'b0;
      t_last[0] = 1'b0;
      t_ordy[0] = 1'b1;
      @(posedge clk);
      #1;
      check("bp_release", 64'({ov(0), rdy(0)}), 64'b01);
      push_exp(0, 16'd1, 32'h0000_0003);
      send_beat(0, {12'd1, 12'd1, 12'd1}, 1'b1);

      // Reset in the middle of a group.
      send_beat(0, {12'd9, 12'd9, 12'd9}, 1'b0);
      send_beat(0, {12'd9, 12'd9, 12'd9}, 1'b0);
      #2 rst = 1'b1;
      #1;
      check("rst_mid_grp", 64'({ov(0), obs_a}), 64'd0);
      rst = 1'b0;
      push_exp(0, 16'd1, 32'h0000_0005);
      send_beat(0, {12'd0, 12'd0, 12'd5}, 1'b1);

      // Reset while a result is pending in OUT discards it.
      n = 0;
      while (exp_q_a.size() != 0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      @(posedge clk);
      #1;
      t_ordy[0] = 1'b0;
      send_beat(0, {12'd0, 12'd0, 12'd4}, 1'b1);
      @(posedge clk);
      #1;
      check("pend_valid", 64'({st_a, ov(0)}), {61'd0, OUT, 1'b1});
      #2 rst = 1'b1;
      #1;
      check("pend_clear", 64'({st_a, ov(0), obs_a}), 64'd0);
      rst = 1'b0;
      t_ordy[0] = 1'b1;
      push_exp(0, 16'd1, 32'h0000_0007);
      send_beat(0, {12'd0, 12'd0, 12'd7}, 1'b1);

      // Drain outstanding expectations.
      n = 0;
      while ((exp_q_a.size() + exp_q_b.size() + exp_q_c.size()) != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("drain", 64'(exp_q_a.size() + exp_q_b.size() + exp_q_c.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/csa_accumulator.md
Name: csa_accumulator

Overview:
- Parametrised multi-operand carry-save accumulator for the GEMM/GEMV datapath.
- Each accepted beat carries NUM_IN operands. They are folded with a tree of 3:2 compressors into a redundant (sum, carry) register pair.
- On the last beat of a group, one carry-propagate add resolves the group total, which is then presented through a valid/ready output.
- Successor to the fixed-width 3:2 CSA: adds width/operand-count parameters, signed mode, accumulation state and handshaking.

Parameters:
- IN_WIDTH, 12, width of each input operand (>=2).
- NUM_IN, 3, operands per input beat (>=2).
- ACC_WIDTH, 32, accumulator and result width (>=IN_WIDTH+1).
- SIGNED, 0, 0 = operands zero-extended; 1 = operands two's-complement and sign-extended to ACC_WIDTH.
- CNT_WIDTH, 16, width of the beat counter.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous and active-high.
- in_valid  input  1  beat present.
- in_ready  output  1  block can accept a beat.
- in_data  input  NUM_IN*IN_WIDTH  packed operands; operand i occupies bits [i*IN_WIDTH +: IN_WIDTH].
- in_last  input  1  beat is the final beat of the current group.
- out_valid  output  1  resolved result present.
- out_ready  input  1  consumer accepts the result.
- out_data  output  ACC_WIDTH  group total, modulo 2^ACC_WIDTH.
- out_beats  output  CNT_WIDTH  number of beats in the group, saturating.

Behaviour:
- Reset (asynchronous assert, release synchronous to clk):
  - state=ACCUM; sum_r, carry_r, cnt_r and out_data all 0.
  - out_valid=0, out_beats=0, in_ready=1 once reset is deasserted.
- Handshakes:
  - Input beat accepted on an edge where in_valid & in_ready.
  - Output consumed on an edge where out_valid & out_ready.
  - out_data and out_beats are held stable while out_valid=1 and out_ready=0.
- States:
  - ACCUM:
    - in_ready=1.
    - On accept: {sum_r, carry_r} <= 3:2-tree reduction of (sum_r, carry_r, ext(op0..opNUM_IN-1)) to two ACC_WIDTH vectors; carries out of the MSB are discarded.
    - cnt_r <= cnt_r+1, saturating at 2^CNT_WIDTH-1.
    - If in_last is also set, next state is RESOLVE.
    - No accept: registers hold.
  - RESOLVE:
    - in_ready=0.
    - One cycle only: out_data <= sum_r+carry_r (mod 2^ACC_WIDTH); out_beats <= cnt_r; out_valid <= 1; next state OUT.
  - OUT:
    - in_ready=0, out_valid=1.
    - On out_ready: out_valid <= 0; sum_r, carry_r and cnt_r <= 0; next state ACCUM.
    - in_ready rises the cycle after the output handshake; back-to-back groups carry a 2-cycle bubble.
- Latency: last beat accepted at edge k → out_valid=1 after edge k+1.
- Arithmetic:
  - ext() zero-extends when SIGNED=0 and sign-extends when SIGNED=1.
  - All compressor levels run at full ACC_WIDTH. The redundant pair's wrapped sum always equals the true running total mod 2^ACC_WIDTH.
  - Overflow wraps silently.
  - Compressor bit 0 carry-in is 0; the carry vector is shifted left by one with bit 0 = 0.
- Boundaries:
  - in_valid while in_ready=0: ignored, not stored; the source must hold.
  - A single-beat group (first beat has in_last) is legal.
  - in_last with in_valid=0 has no effect.
  - A reset at any point, including during RESOLVE or OUT, discards the partial or pending group and returns to reset values.
  - The counter saturates and does not wrap.
- Timing: the tree is purely combinational between in_data and sum_r/carry_r. There is no carry-propagate path except the single adder in RESOLVE.

Decomposition:
- Package csa_pkg:
  - state enum {ACCUM, RESOLVE, OUT}.
  - Function csa_levels(n) giving the number of 3:2 levels needed to reduce n operands to 2.
  - Function sext/zext helper keyed by SIGNED.
- Sub-module csa_3to2_n #(W):
  - Inputs A, B, C [W]; outputs S [W] and Cout [W] (carry already shifted, bit 0 = 0).
  - Instantiated in a generate loop over levels to reduce NUM_IN+2 operands.

Test Plan (defaults unless noted):
- Single beat: in_data={0xFFF,0xFFF,0xFFF}, in_last=1 → out_valid after edge k+1; out_data=0x00002FFD, out_beats=1.
- Multi-beat: four beats of {1,2,3}, last on the 4th → out_data=0x18, out_beats=4; in_ready=0 for exactly RESOLVE plus the OUT cycles.
- SIGNED=1: beat {0x800,0x001,0xFFF}, last → out_data=0xFFFFF800 (−2048).
- Wrap, ACC_WIDTH=14: two beats of {0xFFF,0xFFF,0xFFF} → out_data=0x1FFA (0x5FFA mod 2^14), out_beats=2.
- Backpressure: out_ready held 0 for 5 cycles in OUT → out_data/out_beats stable, in_valid ignored; out_ready=1 → out_valid drops next cycle, in_ready=1; a following group {1,1,1},last → out_data=3, out_beats=1 (no carry-over).
- Reset mid-group: two beats accepted, rst pulsed asynchronously between edges → all outputs 0 immediately; new group {5,0,0},last → out_data=5, out_beats=1.
